periph_bus_ctrl: RTL and testbench
==================================

PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of master and peripheral data paths.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8; the top 2 bits select the device and the low ADDR_WIDTH-2 bits select the register.
REQ-003 SHALL have parameter TIMEOUT, default 15, legal 1..15, max ACCESS cycles waited for ready.
REQ-004 SHALL have ports, with one clock and an asynchronous active-high reset:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- m_req  in  2  per-master request, bit0 = CPU, bit1 = DMA
- m_we  in  2  per-master write (1) / read (0)
- m_addr  in  2*ADDR_WIDTH  per-master address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  2*DATA_WIDTH  per-master write data, same packing
- m_done  out  2  one-cycle completion pulse to the granted master
- m_err  out  1  timeout flag, valid while m_done is nonzero
- m_rdata  out  DATA_WIDTH  read data, held until the next completion
- busy  out  1  high in any state except IDLE
- p_addr  out  ADDR_WIDTH-2  register index to peripherals
- p_wdata  out  DATA_WIDTH  write data to peripherals
- p_read  out  4  per-device read strobe
- p_write  out  4  per-device write strobe
- p_rdata  in  DATA_WIDTH  shared peripheral read data, externally muxed
- p_ready  in  4  per-device ready

Function
REQ-005 SHALL implement the FSM IDLE -> ACCESS -> DONE -> IDLE with no other states.
REQ-006 In IDLE with m_req nonzero, SHALL grant one master and latch that master's we, addr and wdata, then enter ACCESS next cycle.
REQ-007 Arbitration SHALL be round-robin: a single request wins; when both request, the master not granted last wins; the last-granted pointer updates on grant.
REQ-008 In ACCESS, SHALL assert exactly one bit of p_read or p_write, at index latched addr[ADDR_WIDTH-1 -: 2]; all other strobe bits SHALL be 0.
REQ-009 p_addr and p_wdata SHALL come from the latched values and stay stable for the whole ACCESS state.
REQ-010 In ACCESS, SHALL sample p_ready of the selected device only; ready from other devices SHALL be ignored.
REQ-011 On selected ready high in ACCESS, SHALL enter DONE; for a read, SHALL capture p_rdata into m_rdata on that edge.
REQ-012 SHALL use a 4-bit wait counter: cleared on entry to ACCESS, incremented each ACCESS cycle without ready.
REQ-013 When the counter equals TIMEOUT-1 with ready low, SHALL enter DONE with the error flag set and m_rdata unchanged.
REQ-014 Ready arriving in the same cycle as the timeout SHALL count as success, with no error.
REQ-015 In DONE, SHALL pulse m_done[granted] for exactly one cycle and drive m_err, then return to IDLE; m_err SHALL be 0 outside DONE.
REQ-016 Latency: with ready in the first ACCESS cycle, a request sampled in IDLE at cycle N SHALL give m_done at cycle N+2; the minimum time between consecutive grants is 3 cycles.
REQ-017 Requests SHALL be sampled only in IDLE; changes to m_req or m_addr during ACCESS or DONE SHALL have no effect on the transaction in flight.
REQ-018 A master SHALL hold m_req until its m_done; if it is still requesting in the IDLE after DONE, it re-arbitrates normally and wins only when the round-robin rule allows.
REQ-019 All outputs SHALL be driven from registers; strobes SHALL be glitch-free decodes of the state register and the latched address.

Reset
REQ-020 On rst high, asynchronously: state=IDLE, p_read=0, p_write=0, m_done=0, m_err=0, busy=0, m_rdata=0, p_addr=0, p_wdata=0, counter=0, pointer set so CPU (bit0) wins the first tie.
REQ-021 Reset mid-ACCESS SHALL abort the transaction with no m_done pulse; the first grant after release follows REQ-007 from the reset pointer.

Verification
REQ-022 Single CPU read, addr=8'h43, p_ready[1] high in the first ACCESS cycle, p_rdata=32'hCAFE0001 -> p_read=4'b0010 for 1 cycle, p_addr=6'h03, m_done=2'b01 at N+2, m_rdata=32'hCAFE0001, m_err=0.
REQ-023 Both masters request continuously, each completing with immediate ready -> grants alternate CPU, DMA, CPU, DMA, with m_done pulses 3 cycles apart.
REQ-024 DMA write to device 3, wdata=32'h12345678, p_ready[3] asserted after 5 wait cycles -> p_write=4'b1000 held for 6 cycles, p_wdata stable throughout, m_done=2'b10, m_err=0.
REQ-025 CPU read of device 2 with p_ready never asserted, TIMEOUT=15 -> p_read[2] high for exactly 15 cycles, then m_done=2'b01 with m_err=1 and m_rdata unchanged.
REQ-026 p_ready[0] high throughout while device 2 is selected -> ignored, timeout still taken; separately, ready on the timeout cycle -> m_err=0.
REQ-027 rst pulsed during ACCESS -> all strobes 0 in the same cycle, no m_done; after release with both requesting, CPU is granted first.

Source files
------------

// File: rtl/periph_bus_ctrl.sv
// Two-master, four-device peripheral bus controller with round-robin arbitration and a ready timeout.
// Latency: 2 cycles from request to m_done with immediate ready; new requests are accepted only in IDLE.
module periph_bus_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              m_req,
  input  logic [1:0]              m_we,
  input  logic [2*ADDR_WIDTH-1:0] m_addr,
  input  logic [2*DATA_WIDTH-1:0] m_wdata,
  output logic [1:0]              m_done,
  output logic                    m_err,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    busy,
  output logic [ADDR_WIDTH-3:0]   p_addr,
  output logic [DATA_WIDTH-1:0]   p_wdata,
  output logic [3:0]              p_read,
  output logic [3:0]              p_write,
  input  logic [DATA_WIDTH-1:0]   p_rdata,
  input  logic [3:0]              p_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic                    last_q, last_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [1:0]              done_q, done_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-3:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [3:0]              pread_q, pread_d;
  logic [3:0]              pwrite_q, pwrite_d;

  logic [1:0] dev_cur;
  logic [1:0] dev_nxt;
  logic       rdy_sel;

  assign dev_cur = addr_q[ADDR_WIDTH-1 -: 2];
  assign rdy_sel = p_ready[dev_cur];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_req != 2'b00) begin
          // On a tie the master that did not win last time gets the bus.
          gnt_d   = (m_req == 2'b11) ? ~last_q : m_req[1];
          last_d  = gnt_d;
          we_d    = m_we[gnt_d];
          addr_d  = gnt_d ? m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr[ADDR_WIDTH-1:0];
          wdata_d = gnt_d ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (rdy_sel) begin
          state_d = DONE;
          if (!we_q) rdata_d = p_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded from next-state values so every port comes straight off a flop.
  assign dev_nxt = addr_d[ADDR_WIDTH-1 -: 2];

  always_comb begin
    pread_d  = 4'b0000;
    pwrite_d = 4'b0000;
    if (state_d == ACCESS) begin
      if (we_d) pwrite_d = 4'b0001 << dev_nxt;
      else      pread_d  = 4'b0001 << dev_nxt;
    end
    done_d   = (state_d == DONE) ? (2'b01 << gnt_d) : 2'b00;
    busy_d   = (state_d != IDLE);
    paddr_d  = addr_d[ADDR_WIDTH-3:0];
    pwdata_d = wdata_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 4'd0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 2'b00;
      busy_q   <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pread_q  <= 4'b0000;
      pwrite_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pread_q  <= pread_d;
      pwrite_q <= pwrite_d;
    end
  end

  assign m_done  = done_q;
  assign m_err   = err_q;
  assign m_rdata = rdata_q;
  assign busy    = busy_q;
  assign p_addr  = paddr_q;
  assign p_wdata = pwdata_q;
  assign p_read  = pread_q;
  assign p_write = pwrite_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Randomized bench for periph_bus_ctrl against a transaction-level model of arbitration, strobes and timeout.
module tb_periph_bus_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    m_req, m_we;
  logic [2*AW-1:0] m_addr;
  logic [2*DW-1:0] m_wdata;
  logic [1:0]    m_done;
  logic          m_err;
  logic [DW-1:0] m_rdata;
  logic          busy;
  logic [AW-3:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [3:0]    p_read, p_write;
  logic [DW-1:0] p_rdata;
  logic [3:0]    p_ready;

  int n_checks = 0;
  int n_errors = 0;
  int last_gnt;
  logic [DW-1:0] exp_rdata;

  always #5 clk = ~clk;

  periph_bus_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata),
    .busy(busy), .p_addr(p_addr), .p_wdata(p_wdata), .p_read(p_read),
    .p_write(p_write), .p_rdata(p_rdata), .p_ready(p_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete transaction; ready for the selected device rises on ACCESS cycle 'delay'
  // (delay >= TO means it never does). Entered and left at #1 after a rising edge, DUT in IDLE.
  task automatic do_txn(input logic [1:0] req, input logic [1:0] we, input logic [2*AW-1:0] addr,
                        input logic [2*DW-1:0] wdata, input int delay);
    int         w;
    logic [7:0] a;
    logic [1:0] dev;
    logic       wr;
    logic [31:0] wd;
    logic [3:0] strobe;
    logic [31:0] rd;
    logic [3:0] rdy;
    bit         ok;
    m_req   = req;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    p_ready = 4'($urandom);
    p_rdata = $urandom;
    if (req == 2'b01)      w = 0;
    else if (req == 2'b10) w = 1;
    else                   w = 1 - last_gnt;
    last_gnt = w;
    a      = addr[w*AW +: AW];
    wr     = we[w];
    wd     = wdata[w*DW +: DW];
    dev    = a[7:6];
    strobe = 4'b0001 << dev;
    rd     = '0;
    ok     = 0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(m_done), 64'(0));
    check("idle_err", 64'(m_err), 64'(0));
    check("idle_strobe", 64'({p_read, p_write}), 64'(0));
    @(posedge clk); #1;
    m_addr  = 16'($urandom);
    m_wdata = {$urandom, $urandom};
    m_we    = 2'($urandom);
    for (int k = 0; k < TO; k++) begin
      rdy      = 4'($urandom);
      rdy[dev] = (k == delay);
      p_ready  = rdy;
      p_rdata  = $urandom;
      rd       = p_rdata;
      @(negedge clk);
      check("acc_read", 64'(p_read), 64'(wr ? 4'b0000 : strobe));
      check("acc_write", 64'(p_write), 64'(wr ? strobe : 4'b0000));
      check("acc_paddr", 64'(p_addr), 64'(a[5:0]));
      if (wr) check("acc_pwdata", 64'(p_wdata), 64'(wd));
      check("acc_busy", 64'(busy), 64'(1));
      check("acc_done", 64'(m_done), 64'(0));
      @(posedge clk); #1;
      if (k == delay) begin
        ok = 1;
        break;
      end
    end
    if (ok && !wr) exp_rdata = rd;
    p_ready = 4'b0000;
    m_req   = 2'($urandom);
    m_addr  = 16'($urandom);
    @(negedge clk);
    check("done_pulse", 64'(m_done), 64'(2'b01 << w));
    check("done_err", 64'(m_err), 64'(!ok));
    check("done_rdata", 64'(m_rdata), 64'(exp_rdata));
    check("done_strobe", 64'({p_read, p_write}), 64'(0));
    @(posedge clk); #1;
    m_req = 2'b00;
  endtask

  task automatic idle_cycle();
    m_req = 2'b00;
    m_addr = 16'($urandom);
    @(negedge clk);
    check("noreq_busy", 64'(busy), 64'(0));
    check("noreq_strobe", 64'({p_read, p_write}), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int req, dly;
    rst = 1'b1; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; p_rdata = 0; p_ready = 0;
    last_gnt = 1;
    exp_rdata = '0;
    #12;
    check("rst_read", 64'(p_read), 64'(0));
    check("rst_write", 64'(p_write), 64'(0));
    check("rst_done", 64'(m_done), 64'(0));
    check("rst_err", 64'(m_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rdata", 64'(m_rdata), 64'(0));
    check("rst_paddr", 64'(p_addr), 64'(0));
    check("rst_pwdata", 64'(p_wdata), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases: CPU read dev1, DMA write dev3 with wait, CPU read timeout,
    // ready on the timeout cycle, then alternating ties.
    do_txn(2'b01, 2'b00, {8'h00, 8'h43}, 64'h0, 0);
    do_txn(2'b10, 2'b10, {8'hC5, 8'h00}, {32'h12345678, 32'h0}, 5);
    do_txn(2'b01, 2'b00, {8'h00, 8'h81}, 64'h0, 99);
    do_txn(2'b01, 2'b00, {8'h00, 8'h9A}, 64'h0, TO - 1);
    for (int i = 0; i < 4; i++)
      do_txn(2'b11, 2'($urandom), 16'($urandom), {$urandom, $urandom}, 0);

    // Reset while a transaction is in ACCESS.
    m_req = 2'b11; m_we = 2'b00; m_addr = 16'($urandom); p_ready = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_strobe", 64'({p_read, p_write}), 64'(0));
    check("arst_done", 64'(m_done), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_rdata", 64'(m_rdata), 64'(0));
    exp_rdata = '0;
    last_gnt  = 1;
    m_req = 2'b00;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_txn(2'b11, 2'b00, 16'($urandom), {$urandom, $urandom}, 0);

    for (int i = 0; i < 60; i++) begin
      req = $urandom_range(0, 3);
      dly = $urandom_range(0, 18);
      if (req == 0) idle_cycle();
      else do_txn(2'(req), 2'($urandom), 16'($urandom), {$urandom, $urandom}, dly);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
